// File: rtl/mine_game_ctrl_pkg.sv
// Shared types and constants for the mining-game sequencer.
// States: IDLE=0 waiting for start, GEN=1 board generation, PLAY=2 clicks live,
// WIN=3 all mines defused, LOSE=4 mine hit, PAUSED=5 play suspended (PAUSE_EN only).
package mine_game_pkg;

  localparam int MINES_W = 6;
  localparam int SEC_W   = 10;

  localparam logic [1:0] LEVEL_EASY   = 2'd0;
  localparam logic [1:0] LEVEL_MEDIUM = 2'd1;
  localparam logic [1:0] LEVEL_HARD   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GEN    = 3'd1,
    ST_PLAY   = 3'd2,
    ST_WIN    = 3'd3,
    ST_LOSE   = 3'd4,
    ST_PAUSED = 3'd5
  } state_t;

  // Level 3 has no board definition of its own; it plays as easy.
  function automatic logic [1:0] norm_level(input logic [1:0] lvl);
    case (lvl)
      LEVEL_MEDIUM: return LEVEL_MEDIUM;
      LEVEL_HARD:   return LEVEL_HARD;
      default:      return LEVEL_EASY;
    endcase
  endfunction

  // A zero-mine game could never be won, so it is played with one mine.
  function automatic logic [MINES_W-1:0] clamp_mines(input logic [MINES_W-1:0] m);
    return (m == '0) ? MINES_W'(1) : m;
  endfunction

endpackage

// File: rtl/mine_game_ctrl_sec_ticker.sv
// One-second divider and saturating seconds counter for the play timer.
// Clear takes priority over enable; with enable low the divider holds its phase.
module sec_ticker
  import mine_game_pkg::*;
#(
  parameter int CLK_HZ  = 65_000_000,
  parameter int SEC_MAX = 999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [SEC_W-1:0] o_seconds
);

  localparam int               DIV_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DIV_W-1:0] DIV_TC  = DIV_W'(CLK_HZ - 1);
  localparam logic [SEC_W-1:0] SEC_TOP = SEC_W'(SEC_MAX);

  logic [DIV_W-1:0] r_div;
  logic [SEC_W-1:0] r_sec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
      r_sec <= '0;
    end else if (i_clr) begin
      r_div <= '0;
      r_sec <= '0;
    end else if (i_en) begin
      if (r_div == DIV_TC) begin
        r_div <= '0;
        if (r_sec < SEC_TOP) r_sec <= r_sec + SEC_W'(1);
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

  assign o_seconds = r_sec;

endmodule

// File: rtl/mine_game_ctrl.sv
// Mining-game sequencer: start / board generation / play / result, with flag, defuse and seconds counters.
// Build option: define PAUSE_EN to make the pause input move PLAY into PAUSED.
module mine_game_ctrl
  import mine_game_pkg::*;
#(
  parameter int CLK_HZ      = 65_000_000,
  parameter int SEC_MAX     = 999,
  parameter int GEN_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         level,
  input  logic [MINES_W-1:0] mines,
  input  logic               board_ready,
  input  logic               explode,
  input  logic               defuse,
  input  logic               mark_flag,
  input  logic               pause,
  output logic               gen_req,
  output logic               click_en,
  output logic [1:0]         level_q,
  output logic [2:0]         state_o,
  output logic [MINES_W-1:0] flags_left,
  output logic [MINES_W-1:0] defused_cnt,
  output logic [SEC_W-1:0]   seconds,
  output logic               won,
  output logic               lost
);

  localparam int                WAIT_W   = (GEN_TIMEOUT > 1) ? $clog2(GEN_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_TOP = WAIT_W'(GEN_TIMEOUT - 1);

  state_t             r_state, w_state_nxt;
  logic               r_gen_req, w_gen_req_nxt;
  logic               r_click_en, w_click_en_nxt;
  logic               r_won, w_won_nxt;
  logic               r_lost, w_lost_nxt;
  logic [WAIT_W-1:0]  r_wait;
  logic [1:0]         r_level;
  logic [MINES_W-1:0] r_mines, r_flags, r_defused;
  logic               w_play, w_win_hit;

  assign w_play    = (r_state == ST_PLAY);
  assign w_win_hit = defuse && !explode && ((r_defused + MINES_W'(1)) == r_mines);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_gen_req  <= 1'b0;
      r_click_en <= 1'b0;
      r_won      <= 1'b0;
      r_lost     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gen_req  <= w_gen_req_nxt;
      r_click_en <= w_click_en_nxt;
      r_won      <= w_won_nxt;
      r_lost     <= w_lost_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_gen_req_nxt = 1'b0;
    if (start) begin
      w_state_nxt   = ST_GEN;
      w_gen_req_nxt = 1'b1;
    end else begin
      case (r_state)
        // Ready seen in the request cycle may be left over from the previous board.
        ST_GEN: begin
          if (!r_gen_req && board_ready) w_state_nxt = ST_PLAY;
          else if (r_wait == '0)         w_gen_req_nxt = 1'b1;
        end
        ST_PLAY: begin
          if (explode)        w_state_nxt = ST_LOSE;
          else if (w_win_hit) w_state_nxt = ST_WIN;
`ifdef PAUSE_EN
          else if (pause)     w_state_nxt = ST_PAUSED;
`endif
        end
`ifdef PAUSE_EN
        ST_PAUSED: if (!pause) w_state_nxt = ST_PLAY;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    w_click_en_nxt = (w_state_nxt == ST_PLAY);
    w_won_nxt      = (w_state_nxt == ST_WIN);
    w_lost_nxt     = (w_state_nxt == ST_LOSE);
  end

`ifndef PAUSE_EN
  logic w_unused_pause;
  assign w_unused_pause = pause;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait    <= '0;
      r_level   <= '0;
      r_mines   <= '0;
      r_flags   <= '0;
      r_defused <= '0;
    end else if (start) begin
      r_wait    <= WAIT_TOP;
      r_level   <= norm_level(level);
      r_mines   <= clamp_mines(mines);
      r_flags   <= clamp_mines(mines);
      r_defused <= '0;
    end else begin
      if (w_gen_req_nxt)          r_wait <= WAIT_TOP;
      else if (r_state == ST_GEN) r_wait <= r_wait - WAIT_W'(1);
      if (w_play && mark_flag && (r_flags != '0))
        r_flags <= r_flags - MINES_W'(1);
      if (w_play && defuse && !explode && (r_defused != r_mines))
        r_defused <= r_defused + MINES_W'(1);
    end
  end

  sec_ticker #(
    .CLK_HZ (CLK_HZ),
    .SEC_MAX(SEC_MAX)
  ) u_sec_ticker (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_play),
    .i_clr    (start),
    .o_seconds(seconds)
  );

  assign gen_req     = r_gen_req;
  assign click_en    = r_click_en;
  assign level_q     = r_level;
  assign state_o     = r_state;
  assign flags_left  = r_flags;
  assign defused_cnt = r_defused;
  assign won         = r_won;
  assign lost        = r_lost;

endmodule
